isqrt_iter: RTL and testbench



---
 rtl/isqrt_iter.sv | 103 ++++++++++
 tb/tb_isqrt_iter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/isqrt_iter.sv
// Iterative integer square root: one result bit per clock, floor(sqrt(x)) after N/2+1 cycles.
// Single-issue; requests arriving while busy are dropped.
module isqrt_iter #(
    parameter int unsigned N = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [N-1:0]     x,
    output logic             y_vld,
    output logic [N/2-1:0]   y,
    output logic             busy
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [H+1:0]   rem_q, rem_d;
    logic [H-1:0]   root_q, root_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [H-1:0]   y_q, y_d;
    logic           y_vld_q, y_vld_d;

    logic [H+1:0]   rem_sh;
    logic [H+1:0]   trial;
    logic           take;
    logic [H-1:0]   root_nxt;

    // rem never exceeds 2*root+1, so dropping its top two bits on the shift loses nothing
    always_comb begin
        rem_sh   = {rem_q[H-1:0], opnd_q[N-1:N-2]};
        trial    = {root_q, 2'b01};
        take     = (rem_sh >= trial);
        root_nxt = {root_q[H-2:0], take};
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        y_vld_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (x_vld) begin
                    opnd_d  = x;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                opnd_d = opnd_q << 2;
                rem_d  = take ? (rem_sh - trial) : rem_sh;
                root_d = root_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(H - 1)) begin
                    y_d     = root_nxt;
                    y_vld_d = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            opnd_q  <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;
    assign busy  = (state_q == StCalc);

endmodule

// File: tb/tb_isqrt_iter.sv
// Directed and random checks of isqrt_iter: latency, busy window, back-to-back, drop, reset.
module tb_isqrt_iter;

    logic        clk;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int dbl     = 0;
    logic prev_vld = 1'b0;

    isqrt_iter #(.N(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (y_vld && prev_vld) dbl <= dbl + 1;
        prev_vld <= y_vld;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    // Caller is at a negedge; the request is presented in the current cycle (cycle 0).
    task automatic run_op(input string tag, input logic [31:0] xv, input logic [15:0] exp);
        int hit;
        int busy_n;
        hit    = 0;
        busy_n = 0;
        x      = xv;
        x_vld  = 1'b1;
        for (int k = 1; k <= 40 && hit == 0; k++) begin
            @(negedge clk);
            x_vld = 1'b0;
            x     = $urandom;
            if (busy) busy_n++;
            if (y_vld) hit = k;
        end
        check_eq({tag, "_lat"}, hit, 17);
        check_eq({tag, "_y"}, {16'd0, y}, {16'd0, exp});
        check_eq({tag, "_busy"}, busy_n, 16);
    endtask

    initial begin
        int pulses;
        int first;
        int gap;
        logic [15:0] first_y;
        logic [31:0] rv;

        rst   = 1'b0;
        x_vld = 1'b1;
        x     = 32'd49;
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        x_vld = 1'b0;
        @(negedge clk);
        check_eq("rst_y_vld", {31'd0, y_vld}, 0);
        check_eq("rst_y", {16'd0, y}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);

        run_op("x0", 32'd0, 16'd0);
        @(negedge clk);
        run_op("x1", 32'd1, 16'd1);
        @(negedge clk);
        run_op("x15", 32'd15, 16'd3);
        @(negedge clk);
        run_op("x16", 32'd16, 16'd4);
        @(negedge clk);
        run_op("x1e6", 32'd1000000, 16'd1000);
        @(negedge clk);
        run_op("xmax", 32'hFFFFFFFF, 16'hFFFF);
        @(negedge clk);
        run_op("xfffe0001", 32'hFFFE0001, 16'hFFFF);
        @(negedge clk);
        run_op("xfffe0000", 32'hFFFE0000, 16'hFFFE);
        @(negedge clk);

        // back-to-back: second request in the DONE cycle of the first
        run_op("b2b49", 32'd49, 16'd7);
        run_op("b2b81", 32'd81, 16'd9);
        @(negedge clk);

        // drop while busy
        pulses  = 0;
        first   = 0;
        first_y = '0;
        x       = 32'd100;
        x_vld   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            x_vld = 1'b0;
            if (k == 5) begin
                x_vld = 1'b1;
                x     = 32'd4;
            end
            if (y_vld) begin
                pulses++;
                if (first == 0) begin
                    first   = k;
                    first_y = y;
                end
            end
        end
        check_eq("drop_pulses", pulses, 1);
        check_eq("drop_lat", first, 17);
        check_eq("drop_y", {16'd0, first_y}, 32'd10);

        // reset mid-operation
        @(negedge clk);
        pulses = 0;
        x      = 32'd144;
        x_vld  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            x_vld = 1'b0;
            rst   = (k == 8) ? 1'b0 : 1'b1;
            if (y_vld) pulses++;
            if (k == 9) begin
                check_eq("mid_rst_y", {16'd0, y}, 0);
                check_eq("mid_rst_busy", {31'd0, busy}, 0);
            end
        end
        check_eq("mid_rst_pulses", pulses, 0);
        run_op("after_rst", 32'd144, 16'd12);

        for (int i = 0; i < 2000; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            rv = $urandom;
            if (i % 4 == 0) rv = $urandom_range(0, 1023);
            run_op("rand", rv, ref_sqrt(rv));
        end

        @(negedge clk);
        check_eq("no_double_vld", dbl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
